// File: rtl/register_port_sequencer_8088.sv
// Arbitrates two requesters onto the 8088 register bank ports and sequences READ, WRITE and XCHG.
// Optional macro REG_SEQ_SP_PROTECT_EN refuses req0 WRITE/XCHG that targets SP.
module register_port_sequencer_8088 #(
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned REG_AW     = 3,
   parameter int unsigned FIRST_PRIO = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [1:0]        req0_op,
   input  logic [REG_AW-1:0] req0_reg_a,
   input  logic [REG_AW-1:0] req0_reg_b,
   input  logic [DATA_W-1:0] req0_data,
   input  logic              req0_size,
   input  logic              req0_high_low,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [1:0]        req1_op,
   input  logic [REG_AW-1:0] req1_reg_a,
   input  logic [REG_AW-1:0] req1_reg_b,
   input  logic [DATA_W-1:0] req1_data,
   input  logic              req1_size,
   input  logic              req1_high_low,
   output logic              en_write,
   output logic [REG_AW-1:0] reg_write,
   output logic [DATA_W-1:0] write_data,
   output logic [REG_AW-1:0] reg_read1,
   output logic [REG_AW-1:0] reg_read2,
   output logic              size,
   output logic              select_high_low,
   input  logic [DATA_W-1:0] read_data1,
   input  logic [DATA_W-1:0] read_data2,
   output logic              rsp_valid,
   output logic              rsp_id,
   output logic [DATA_W-1:0] rsp_data1,
   output logic [DATA_W-1:0] rsp_data2,
   output logic              rsp_err
);

   localparam logic [1:0] OpWrite = 2'b00;
   localparam logic [1:0] OpXchg  = 2'b10;

   typedef enum logic [2:0] {StIdle, StRd, StWr, StXRd, StXWa, StXWb, StResp} state_e;

   state_e            state;
   logic              last_grant;
   logic [REG_AW-1:0] cmd_a;
   logic [REG_AW-1:0] cmd_b;

   logic              is_idle;
   logic              grant0;
   logic              grant1;
   logic              accept;
   logic [1:0]        sel_op;
   logic [REG_AW-1:0] sel_a;
   logic [REG_AW-1:0] sel_b;
   logic [DATA_W-1:0] sel_data;
   logic              sel_size;
   logic              sel_hl;
   logic              refuse;

   // Gating with reset keeps both readies low while reset is held.
   assign is_idle    = (state == StIdle) && reset;
   assign grant0     = req0_valid && (!req1_valid || last_grant);
   assign grant1     = req1_valid && (!req0_valid || !last_grant);
   assign req0_ready = is_idle && grant0;
   assign req1_ready = is_idle && grant1;
   assign accept     = req0_ready || req1_ready;

   assign sel_op   = grant1 ? req1_op       : req0_op;
   assign sel_a    = grant1 ? req1_reg_a    : req0_reg_a;
   assign sel_b    = grant1 ? req1_reg_b    : req0_reg_b;
   assign sel_data = grant1 ? req1_data     : req0_data;
   assign sel_size = grant1 ? req1_size     : req0_size;
   assign sel_hl   = grant1 ? req1_high_low : req0_high_low;

`ifdef REG_SEQ_SP_PROTECT_EN
   localparam logic [REG_AW-1:0] SpIdx = REG_AW'(4);
   assign refuse = !grant1 &&
                   (((sel_op == OpWrite) && (sel_a == SpIdx)) ||
                    ((sel_op == OpXchg) && ((sel_a == SpIdx) || (sel_b == SpIdx))));
`else
   assign refuse = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state           <= StIdle;
         last_grant      <= (FIRST_PRIO == 0);
         cmd_a           <= '0;
         cmd_b           <= '0;
         en_write        <= 1'b0;
         reg_write       <= '0;
         write_data      <= '0;
         reg_read1       <= '0;
         reg_read2       <= '0;
         size            <= 1'b0;
         select_high_low <= 1'b0;
         rsp_valid       <= 1'b0;
         rsp_id          <= 1'b0;
         rsp_data1       <= '0;
         rsp_data2       <= '0;
         rsp_err         <= 1'b0;
      end else begin
         unique case (state)
            StIdle: begin
               if (accept) begin
                  last_grant      <= grant1;
                  rsp_id          <= grant1;
                  cmd_a           <= sel_a;
                  cmd_b           <= sel_b;
                  size            <= sel_size;
                  select_high_low <= sel_hl;
                  rsp_data1       <= '0;
                  rsp_data2       <= '0;
                  rsp_err         <= 1'b0;
                  if (refuse) begin
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     state     <= StResp;
                  end else if (sel_op == OpWrite) begin
                     en_write   <= 1'b1;
                     reg_write  <= sel_a;
                     write_data <= sel_data;
                     state      <= StWr;
                  end else begin
                     // Reserved op 11 falls through to READ.
                     reg_read1 <= sel_a;
                     reg_read2 <= sel_b;
                     state     <= (sel_op == OpXchg) ? StXRd : StRd;
                  end
               end
            end
            StRd: begin
               rsp_data1 <= read_data1;
               rsp_data2 <= read_data2;
               rsp_valid <= 1'b1;
               state     <= StResp;
            end
            StWr: begin
               en_write  <= 1'b0;
               rsp_valid <= 1'b1;
               state     <= StResp;
            end
            StXRd: begin
               rsp_data1  <= read_data1;
               rsp_data2  <= read_data2;
               en_write   <= 1'b1;
               reg_write  <= cmd_a;
               write_data <= read_data2;
               state      <= StXWa;
            end
            StXWa: begin
               reg_write  <= cmd_b;
               write_data <= rsp_data1;
               state      <= StXWb;
            end
            StXWb: begin
               en_write  <= 1'b0;
               rsp_valid <= 1'b1;
               state     <= StResp;
            end
            StResp: begin
               rsp_valid       <= 1'b0;
               rsp_err         <= 1'b0;
               reg_write       <= '0;
               write_data      <= '0;
               reg_read1       <= '0;
               reg_read2       <= '0;
               size            <= 1'b0;
               select_high_low <= 1'b0;
               state           <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_register_port_sequencer_8088.sv
// Directed bench for register_port_sequencer_8088 with a behavioural register bank.
module tb_register_port_sequencer_8088;

   logic        clk;
   logic        reset;
   logic        req0_valid, req0_ready, req0_size, req0_high_low;
   logic [1:0]  req0_op;
   logic [2:0]  req0_reg_a, req0_reg_b;
   logic [15:0] req0_data;
   logic        req1_valid, req1_ready, req1_size, req1_high_low;
   logic [1:0]  req1_op;
   logic [2:0]  req1_reg_a, req1_reg_b;
   logic [15:0] req1_data;
   logic        en_write, size, select_high_low;
   logic [2:0]  reg_write, reg_read1, reg_read2;
   logic [15:0] write_data, read_data1, read_data2;
   logic        rsp_valid, rsp_id, rsp_err;
   logic [15:0] rsp_data1, rsp_data2;

   logic        bank_init;
   logic [15:0] bank [8];
   int          vectors;
   int          miscompares;

   register_port_sequencer_8088 dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_reg_a(req0_reg_a), .req0_reg_b(req0_reg_b), .req0_data(req0_data),
      .req0_size(req0_size), .req0_high_low(req0_high_low),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_reg_a(req1_reg_a), .req1_reg_b(req1_reg_b), .req1_data(req1_data),
      .req1_size(req1_size), .req1_high_low(req1_high_low),
      .en_write(en_write), .reg_write(reg_write), .write_data(write_data),
      .reg_read1(reg_read1), .reg_read2(reg_read2), .size(size),
      .select_high_low(select_high_low), .read_data1(read_data1), .read_data2(read_data2),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data1(rsp_data1), .rsp_data2(rsp_data2),
      .rsp_err(rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bank model: 8-bit writes take the low byte of write_data into the selected half.
   always @(posedge clk) begin
      if (bank_init) begin
         for (int i = 0; i < 8; i++) bank[i] <= 16'h0000;
      end else if (en_write) begin
         if (size) bank[reg_write] <= write_data;
         else if (select_high_low) bank[reg_write][15:8] <= write_data[7:0];
         else bank[reg_write][7:0] <= write_data[7:0];
      end
   end
   assign read_data1 = bank[reg_read1];
   assign read_data2 = bank[reg_read2];

   // Presents one request and returns just after its accepting edge.
   task automatic issue(input int id, input logic [1:0] op, input logic [2:0] a,
                        input logic [2:0] b, input logic [15:0] d, input logic sz,
                        input logic hl, output bit ok);
      @(negedge clk);
      if (id == 0) begin
         req0_op = op; req0_reg_a = a; req0_reg_b = b; req0_data = d;
         req0_size = sz; req0_high_low = hl; req0_valid = 1'b1;
      end else begin
         req1_op = op; req1_reg_a = a; req1_reg_b = b; req1_data = d;
         req1_size = sz; req1_high_low = hl; req1_valid = 1'b1;
      end
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         #1;
         if ((id == 0) ? req0_ready : req1_ready) begin
            ok = 1'b1;
            @(posedge clk);
            #1;
            if (id == 0) req0_valid = 1'b0;
            else req1_valid = 1'b0;
         end else begin
            @(negedge clk);
         end
      end
      if (!ok) begin
         req0_valid = 1'b0;
         req1_valid = 1'b0;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; bank_init = 1'b1;
      req0_valid = 1'b1; req0_op = 2'b00; req0_reg_a = 3'd0;
      repeat (3) @(negedge clk);
      #1;
      vectors++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin miscompares++;
         $display("FAIL rst_ready: got %b%b want 00", req0_ready, req1_ready); end
      vectors++; if (en_write !== 1'b0 || reg_write !== 3'd0 || write_data !== 16'h0) begin
         miscompares++; $display("FAIL rst_bank: got en=%b reg=%0d wd=%h want 0", en_write,
                                 reg_write, write_data); end
      vectors++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_data1 !== 16'h0) begin
         miscompares++; $display("FAIL rst_rsp: got v=%b e=%b d=%h want 0", rsp_valid,
                                 rsp_err, rsp_data1); end
      bank_init = 1'b0;
      reset = 1'b1;
      #1;
      vectors++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin miscompares++;
         $display("FAIL rst_release_ready: got %b%b want 10", req0_ready, req1_ready); end
      req0_valid = 1'b0;
   endtask

   task automatic test_arbitration();
      int  grant_seq[3];
      int  rsp_seq[3];
      int  exp_seq[3];
      int  ng;
      int  nr;
      bit  both_seen;
      exp_seq = '{0, 1, 0};
      ng = 0; nr = 0; both_seen = 1'b0;
      @(negedge clk);
      req0_op = 2'b00; req0_reg_a = 3'd1; req0_reg_b = 3'd0; req0_data = 16'h3456;
      req0_size = 1'b1; req0_high_low = 1'b0; req0_valid = 1'b1;
      req1_op = 2'b00; req1_reg_a = 3'd2; req1_reg_b = 3'd0; req1_data = 16'h789A;
      req1_size = 1'b1; req1_high_low = 1'b0; req1_valid = 1'b1;
      for (int cyc = 0; cyc < 40 && (ng < 3 || nr < 3); cyc++) begin
         if (cyc != 0) @(negedge clk);
         #1;
         if (rsp_valid && nr < 3) begin rsp_seq[nr] = int'(rsp_id); nr++; end
         if (req0_ready && req1_ready) both_seen = 1'b1;
         else if ((req0_ready || req1_ready) && ng < 3) begin
            grant_seq[ng] = req1_ready ? 1 : 0;
            ng++;
            if (ng == 3) begin
               @(posedge clk); #1;
               req0_valid = 1'b0; req1_valid = 1'b0;
            end
         end
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      vectors++; if (both_seen) begin miscompares++;
         $display("FAIL arb_exclusive: got both ready want one"); end
      vectors++; if (ng != 3 || nr != 3) begin miscompares++;
         $display("FAIL arb_count: got grants=%0d rsps=%0d want 3/3", ng, nr); end
      for (int k = 0; k < 3; k++) begin
         vectors++; if (k < ng && grant_seq[k] != exp_seq[k]) begin miscompares++;
            $display("FAIL arb_grant%0d: got %0d want %0d", k, grant_seq[k], exp_seq[k]); end
         vectors++; if (k < nr && rsp_seq[k] != exp_seq[k]) begin miscompares++;
            $display("FAIL arb_rsp_id%0d: got %0d want %0d", k, rsp_seq[k], exp_seq[k]); end
      end
   endtask

   task automatic test_write_read();
      bit ok;
      issue(0, 2'b00, 3'd0, 3'd0, 16'hABCD, 1'b1, 1'b0, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL wr_accept: got timeout"); end
      @(negedge clk); #1;
      vectors++; if (en_write !== 1'b1 || reg_write !== 3'd0 || write_data !== 16'hABCD ||
                     size !== 1'b1 || rsp_valid !== 1'b0) begin miscompares++;
         $display("FAIL wr_n1: got en=%b reg=%0d wd=%h sz=%b rv=%b want 1 0 abcd 1 0",
                  en_write, reg_write, write_data, size, rsp_valid); end
      @(negedge clk); #1;
      vectors++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data1 !== 16'h0 ||
                     en_write !== 1'b0) begin miscompares++;
         $display("FAIL wr_rsp: got rv=%b id=%b d1=%h en=%b want 1 0 0000 0",
                  rsp_valid, rsp_id, rsp_data1, en_write); end
      issue(0, 2'b01, 3'd0, 3'd3, 16'h0, 1'b1, 1'b0, ok);
      @(negedge clk); #1;
      vectors++; if (reg_read1 !== 3'd0 || reg_read2 !== 3'd3 || en_write !== 1'b0) begin
         miscompares++; $display("FAIL rd_n1: got r1=%0d r2=%0d en=%b want 0 3 0",
                                 reg_read1, reg_read2, en_write); end
      @(negedge clk); #1;
      vectors++; if (rsp_valid !== 1'b1 || rsp_data1 !== 16'hABCD || rsp_data2 !== 16'h0000)
      begin miscompares++; $display("FAIL rd_rsp: got rv=%b d1=%h d2=%h want 1 abcd 0000",
                                    rsp_valid, rsp_data1, rsp_data2); end
   endtask

   task automatic test_xchg();
      bit ok;
      issue(1, 2'b10, 3'd1, 3'd2, 16'h0, 1'b1, 1'b0, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL xchg_accept: got timeout"); end
      @(negedge clk); #1;
      vectors++; if (en_write !== 1'b0 || reg_read1 !== 3'd1 || reg_read2 !== 3'd2) begin
         miscompares++; $display("FAIL xchg_rd: got en=%b r1=%0d r2=%0d want 0 1 2",
                                 en_write, reg_read1, reg_read2); end
      @(negedge clk); #1;
      vectors++; if (en_write !== 1'b1 || reg_write !== 3'd1 || write_data !== 16'h789A) begin
         miscompares++; $display("FAIL xchg_wa: got en=%b reg=%0d wd=%h want 1 1 789a",
                                 en_write, reg_write, write_data); end
      @(negedge clk); #1;
      vectors++; if (en_write !== 1'b1 || reg_write !== 3'd2 || write_data !== 16'h3456) begin
         miscompares++; $display("FAIL xchg_wb: got en=%b reg=%0d wd=%h want 1 2 3456",
                                 en_write, reg_write, write_data); end
      @(negedge clk); #1;
      vectors++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data1 !== 16'h3456 ||
                     rsp_data2 !== 16'h789A || en_write !== 1'b0) begin miscompares++;
         $display("FAIL xchg_rsp: got rv=%b id=%b d1=%h d2=%h en=%b want 1 1 3456 789a 0",
                  rsp_valid, rsp_id, rsp_data1, rsp_data2, en_write); end
      issue(0, 2'b01, 3'd1, 3'd2, 16'h0, 1'b1, 1'b0, ok);
      repeat (2) @(negedge clk);
      #1;
      vectors++; if (rsp_valid !== 1'b1 || rsp_data1 !== 16'h789A || rsp_data2 !== 16'h3456)
      begin miscompares++; $display("FAIL xchg_readback: got rv=%b d1=%h d2=%h want 1 789a 3456",
                                    rsp_valid, rsp_data1, rsp_data2); end
   endtask

   task automatic test_8bit();
      bit ok;
      issue(0, 2'b00, 3'd3, 3'd0, 16'h00EF, 1'b0, 1'b0, ok);
      @(negedge clk); #1;
      vectors++; if (en_write !== 1'b1 || reg_write !== 3'd3 || size !== 1'b0 ||
                     select_high_low !== 1'b0) begin miscompares++;
         $display("FAIL b8_low: got en=%b reg=%0d sz=%b hl=%b want 1 3 0 0",
                  en_write, reg_write, size, select_high_low); end
      @(negedge clk);
      issue(0, 2'b00, 3'd3, 3'd0, 16'h0012, 1'b0, 1'b1, ok);
      @(negedge clk); #1;
      vectors++; if (en_write !== 1'b1 || size !== 1'b0 || select_high_low !== 1'b1) begin
         miscompares++; $display("FAIL b8_high: got en=%b sz=%b hl=%b want 1 0 1",
                                 en_write, size, select_high_low); end
      @(negedge clk);
      issue(0, 2'b01, 3'd3, 3'd0, 16'h0, 1'b1, 1'b0, ok);
      repeat (2) @(negedge clk);
      #1;
      vectors++; if (rsp_valid !== 1'b1 || rsp_data1 !== 16'h12EF || rsp_data2 !== 16'hABCD)
      begin miscompares++; $display("FAIL b8_readback: got rv=%b d1=%h d2=%h want 1 12ef abcd",
                                    rsp_valid, rsp_data1, rsp_data2); end
   endtask

   task automatic test_reset_mid_xchg();
      bit ok;
      bit bad;
      issue(0, 2'b10, 3'd0, 3'd3, 16'h0, 1'b1, 1'b0, ok);
      repeat (2) @(negedge clk);
      #1;
      vectors++; if (en_write !== 1'b1) begin miscompares++;
         $display("FAIL mid_pre: got en=%b want 1", en_write); end
      reset = 1'b0;
      #1;
      vectors++; if (en_write !== 1'b0) begin miscompares++;
         $display("FAIL mid_en_drop: got %b want 0", en_write); end
      bad = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         if (rsp_valid || en_write) bad = 1'b1;
      end
      vectors++; if (bad) begin miscompares++;
         $display("FAIL mid_quiet: got activity in reset want none"); end
      reset = 1'b1;
      issue(0, 2'b01, 3'd0, 3'd3, 16'h0, 1'b1, 1'b0, ok);
      repeat (2) @(negedge clk);
      #1;
      vectors++; if (rsp_valid !== 1'b1 || rsp_data1 !== 16'hABCD || rsp_data2 !== 16'h12EF)
      begin miscompares++; $display("FAIL mid_bank: got rv=%b d1=%h d2=%h want 1 abcd 12ef",
                                    rsp_valid, rsp_data1, rsp_data2); end
   endtask

   task automatic test_sp_protect();
      bit ok;
      issue(0, 2'b00, 3'd4, 3'd0, 16'hFFFC, 1'b1, 1'b0, ok);
      @(negedge clk); #1;
`ifdef REG_SEQ_SP_PROTECT_EN
      vectors++; if (en_write !== 1'b0 || rsp_valid !== 1'b1 || rsp_err !== 1'b1 ||
                     rsp_data1 !== 16'h0) begin miscompares++;
         $display("FAIL sp_refuse: got en=%b rv=%b err=%b d1=%h want 0 1 1 0000",
                  en_write, rsp_valid, rsp_err, rsp_data1); end
`else
      vectors++; if (en_write !== 1'b1 || reg_write !== 3'd4 || write_data !== 16'hFFFC) begin
         miscompares++; $display("FAIL sp_write: got en=%b reg=%0d wd=%h want 1 4 fffc",
                                 en_write, reg_write, write_data); end
      @(negedge clk); #1;
      vectors++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin miscompares++;
         $display("FAIL sp_rsp: got rv=%b err=%b want 1 0", rsp_valid, rsp_err); end
`endif
      @(negedge clk);
      issue(1, 2'b00, 3'd4, 3'd0, 16'h1234, 1'b1, 1'b0, ok);
      @(negedge clk); #1;
      vectors++; if (en_write !== 1'b1 || reg_write !== 3'd4) begin miscompares++;
         $display("FAIL sp_req1_write: got en=%b reg=%0d want 1 4", en_write, reg_write); end
      @(negedge clk); #1;
      vectors++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_id !== 1'b1) begin
         miscompares++; $display("FAIL sp_req1_rsp: got rv=%b err=%b id=%b want 1 0 1",
                                 rsp_valid, rsp_err, rsp_id); end
   endtask

   initial begin
      vectors = 0; miscompares = 0;
      req0_valid = 1'b0; req0_op = 2'b00; req0_reg_a = 3'd0; req0_reg_b = 3'd0;
      req0_data = 16'h0; req0_size = 1'b0; req0_high_low = 1'b0;
      req1_valid = 1'b0; req1_op = 2'b00; req1_reg_a = 3'd0; req1_reg_b = 3'd0;
      req1_data = 16'h0; req1_size = 1'b0; req1_high_low = 1'b0;
      test_reset();
      test_arbitration();
      test_write_read();
      test_xchg();
      test_8bit();
      test_reset_mid_xchg();
      test_sp_protect();
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
